// File: rtl/lcd_controller.sv
// Write-only HD44780-style LCD sequencer: runs the power-up init sequence, then
// turns accepted command/data bytes into RS/E/DATA bus cycles with execution waits.
module lcd_controller #(
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned PULSE_CYCLES      = 12,
    parameter int unsigned HOLD_CYCLES       = 2,
    parameter int unsigned SHORT_WAIT_CYCLES = 2000,
    parameter int unsigned LONG_WAIT_CYCLES  = 82000,
    parameter int unsigned INIT_WAIT_CYCLES  = 205000,
    parameter int unsigned POWERUP_CYCLES    = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYCLES =
        max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES), max2(HOLD_CYCLES, SHORT_WAIT_CYCLES)),
             max2(max2(LONG_WAIT_CYCLES, INIT_WAIT_CYCLES), POWERUP_CYCLES));
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [2:0] S_POWERUP   = 3'd0;
    localparam logic [2:0] S_INIT_LOAD = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_PULSE     = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
    localparam logic [2:0] S_WAIT      = 3'd5;
    localparam logic [2:0] S_IDLE      = 3'd6;

    localparam logic [2:0] LAST_INIT_IDX = 3'd6;

    // Each phase lasts n cycles: load n-1 on entry, leave when the counter reads 0.
    function automatic cnt_t phase_load(input int unsigned n);
        return cnt_t'(n - 1);
    endfunction

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h38;
            3'd2:    return 8'h38;
            3'd3:    return 8'h08;
            3'd4:    return 8'h01;
            3'd5:    return 8'h06;
            3'd6:    return 8'h0C;
            default: return 8'h00;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) are the slow commands; the first two
    // function-set writes of the init sequence need the long settle time.
    function automatic cnt_t wait_load(input logic       in_init,
                                       input logic [2:0] idx,
                                       input logic       rs,
                                       input logic [7:0] data);
        if (in_init && (idx < 3'd2))
            return phase_load(INIT_WAIT_CYCLES);
        else if (!rs && (data[7:2] == 6'd0) && (data != 8'h00))
            return phase_load(LONG_WAIT_CYCLES);
        else
            return phase_load(SHORT_WAIT_CYCLES);
    endfunction

    logic [2:0] state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       e_q, e_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rs_d    = rs_q;
        data_d  = data_q;
        e_d     = e_q;
        ready_d = ready_q;
        done_d  = done_q;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == cnt_t'(0))
                    state_d = S_INIT_LOAD;
                else
                    cnt_d = cnt_q - cnt_t'(1);
            end

            S_INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = init_rom(idx_q);
                cnt_d   = phase_load(SETUP_CYCLES);
                state_d = S_SETUP;
            end

            S_SETUP: begin
                if (cnt_q == cnt_t'(0)) begin
                    e_d     = 1'b1;
                    cnt_d   = phase_load(PULSE_CYCLES);
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            S_PULSE: begin
                if (cnt_q == cnt_t'(0)) begin
                    e_d     = 1'b0;
                    cnt_d   = phase_load(HOLD_CYCLES);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            S_HOLD: begin
                if (cnt_q == cnt_t'(0)) begin
                    cnt_d   = wait_load(!done_q, idx_q, rs_q, data_q);
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            S_WAIT: begin
                if (cnt_q == cnt_t'(0)) begin
                    if (!done_q && (idx_q != LAST_INIT_IDX)) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_INIT_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            S_IDLE: begin
                if (req_valid && ready_q) begin
                    rs_d    = req_rs;
                    data_d  = req_data;
                    ready_d = 1'b0;
                    cnt_d   = phase_load(SETUP_CYCLES);
                    state_d = S_SETUP;
                end
            end

            default: begin
                e_d     = 1'b0;
                ready_d = 1'b0;
                cnt_d   = phase_load(POWERUP_CYCLES);
                state_d = S_POWERUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_POWERUP;
            cnt_q   <= phase_load(POWERUP_CYCLES);
            idx_q   <= 3'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign init_done = done_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_data  = data_q;

endmodule
